// File: rtl/operand_seq_pkg.sv
// Shared instruction encoding for the operand sequencer.
// Both the top level and the bench import these codes from here.
package operand_seq_pkg;

    localparam int TX_W = 4;

    typedef enum logic [TX_W-1:0] {
        TX_CLEAR = 4'd0,
        TX_LOAD  = 4'd1,
        TX_HOLD  = 4'd2
    } tx_e;

endpackage

// File: rtl/phase_counter.sv
// Free-running phase counter: counts 0..PHASES-1 and wraps, ignoring any
// instruction. A synchronous active-low reset returns it to phase 0.
module phase_counter #(
    parameter int PHASES = 6,
    parameter int SW     = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic [SW-1:0] current_state
);

    logic [SW-1:0] phase_p1 = '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_p1 <= '0;
        end else if (phase_p1 == SW'(PHASES - 1)) begin
            phase_p1 <= '0;
        end else begin
            phase_p1 <= phase_p1 + 1'b1;
        end
    end

    assign current_state = phase_p1;

endmodule

// File: rtl/operand_sequencer.sv
// Round-robin operand loader with a free-running phase counter.
// Define OPERAND_SEQ_PARITY_EN to add the registered entrada_parity output.
module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int NUM_CH = 2,
    parameter int PHASES = 6,
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int SW    = (PHASES > 1) ? $clog2(PHASES) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [TX_W-1:0]          tx,
    input  logic [NUM_CH*DATA_W-1:0] in_bus,
    output logic [DATA_W-1:0]        entrada,
    output logic                     entrada_valid,
    output logic [CW-1:0]            contador,
    output logic                     load_done,
    output logic [SW-1:0]            current_state
`ifdef OPERAND_SEQ_PARITY_EN
    ,
    output logic                     entrada_parity
`endif
);

    function automatic logic even_parity(input logic [DATA_W-1:0] value);
        return ^value;
    endfunction

    logic [DATA_W-1:0] entrada_p1  = '0;
    logic              vld_p1      = 1'b0;
    logic [CW-1:0]     contador_p1 = '0;
    logic              done_p1     = 1'b0;
    logic              parity_p1   = 1'b0;

    logic [DATA_W-1:0] sel_p0;
    logic [DATA_W-1:0] entrada_next;
    logic              vld_next;
    logic [CW-1:0]     contador_next;
    logic              done_next;
    logic              last_ch;

    assign sel_p0  = in_bus[contador_p1*DATA_W +: DATA_W];
    assign last_ch = (contador_p1 == CW'(NUM_CH - 1));

    // Stage p0: decode the instruction against the current channel pointer.
    always_comb begin
        entrada_next  = entrada_p1;
        vld_next      = 1'b0;
        contador_next = contador_p1;
        done_next     = 1'b0;
        case (tx)
            TX_CLEAR: begin
                entrada_next  = '0;
                contador_next = '0;
            end
            TX_LOAD: begin
                entrada_next  = sel_p0;
                vld_next      = 1'b1;
                contador_next = last_ch ? '0 : contador_p1 + 1'b1;
                done_next     = last_ch;
            end
            default: begin
            end
        endcase
    end

    // Stage p1: registered outputs; reset discards any partial load round.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            entrada_p1  <= '0;
            vld_p1      <= 1'b0;
            contador_p1 <= '0;
            done_p1     <= 1'b0;
            parity_p1   <= 1'b0;
        end else begin
            entrada_p1  <= entrada_next;
            vld_p1      <= vld_next;
            contador_p1 <= contador_next;
            done_p1     <= done_next;
            parity_p1   <= even_parity(entrada_next);
        end
    end

    assign entrada       = entrada_p1;
    assign entrada_valid = vld_p1;
    assign contador      = contador_p1;
    assign load_done     = done_p1;

`ifdef OPERAND_SEQ_PARITY_EN
    assign entrada_parity = parity_p1;
`else
    logic unused_parity;
    assign unused_parity = parity_p1;
`endif

    phase_counter #(
        .PHASES (PHASES),
        .SW     (SW)
    ) u_phase (
        .clock         (clock),
        .reset_n       (reset_n),
        .current_state (current_state)
    );

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: default build, a 4x8 build and a
// PHASES=3 build sharing one clock and reset.
module tb_operand_sequencer;
    import operand_seq_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] tx = TX_HOLD;
    logic [3:0] tx2 = TX_HOLD;

    logic [7:0]  in_bus1 = {4'hB, 4'h5};
    logic [3:0]  entrada1;
    logic        valid1;
    logic [0:0]  contador1;
    logic        done1;
    logic [2:0]  state1;

    logic [31:0] in_bus2 = {8'h81, 8'h07, 8'h30, 8'hFF};
    logic [7:0]  entrada2;
    logic        valid2;
    logic [1:0]  contador2;
    logic        done2;
    logic [2:0]  state2;
`ifdef OPERAND_SEQ_PARITY_EN
    logic        parity2;
`endif

    logic [7:0]  in_bus3 = {4'hB, 4'h5};
    logic [3:0]  entrada3;
    logic        valid3;
    logic [0:0]  contador3;
    logic        done3;
    logic [1:0]  state3;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    operand_sequencer dut1 (
        .clock(clock), .reset_n(reset_n), .tx(tx), .in_bus(in_bus1),
        .entrada(entrada1), .entrada_valid(valid1), .contador(contador1),
        .load_done(done1), .current_state(state1)
    );

    operand_sequencer #(.DATA_W(8), .NUM_CH(4), .PHASES(6)) dut2 (
        .clock(clock), .reset_n(reset_n), .tx(tx2), .in_bus(in_bus2),
        .entrada(entrada2), .entrada_valid(valid2), .contador(contador2),
        .load_done(done2), .current_state(state2)
`ifdef OPERAND_SEQ_PARITY_EN
        , .entrada_parity(parity2)
`endif
    );

    operand_sequencer #(.PHASES(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .tx(tx), .in_bus(in_bus3),
        .entrada(entrada3), .entrada_valid(valid3), .contador(contador3),
        .load_done(done3), .current_state(state3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input logic rn, input logic [3:0] t, input logic [3:0] t2);
        @(negedge clock);
        reset_n = rn;
        tx      = t;
        tx2     = t2;
        @(posedge clock);
        #1;
    endtask

    task automatic check1(input string tag, input logic [3:0] e, input logic v,
                          input logic c, input logic d);
        check({tag, ".entrada"}, 32'(entrada1), 32'(e));
        check({tag, ".valid"}, 32'(valid1), 32'(v));
        check({tag, ".contador"}, 32'(contador1), 32'(c));
        check({tag, ".load_done"}, 32'(done1), 32'(d));
    endtask

    initial begin
        logic [3:0] exp_e[4] = '{4'h5, 4'hB, 4'h5, 4'hB};

        // Reset wins over a LOAD instruction.
        tick(1'b0, TX_LOAD, TX_LOAD);
        check1("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        check("reset.state1", 32'(state1), 32'd0);
        check("reset.state3", 32'(state3), 32'd0);
        check("reset.entrada2", 32'(entrada2), 32'd0);

        // Free-running phase: 12 more cycles after the reset edge.
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, TX_HOLD, TX_HOLD);
            check($sformatf("phase6[%0d]", i), 32'(state1), 32'(i % 6));
            check($sformatf("phase3[%0d]", i), 32'(state3), 32'(i % 3));
        end
        check1("idle", 4'h0, 1'b0, 1'b0, 1'b0);

        // Back-to-back LOADs.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, TX_LOAD, TX_HOLD);
            check1($sformatf("load%0d", i), exp_e[i], 1'b1, 1'((i + 1) % 2), 1'(i % 2));
        end

        // LOAD, then HOLD and undefined codes retain state.
        tick(1'b1, TX_LOAD, TX_HOLD);
        check1("load_once", 4'h5, 1'b1, 1'b1, 1'b0);
        tick(1'b1, TX_HOLD, TX_HOLD);
        check1("hold_a", 4'h5, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 4'd15, TX_HOLD);
        check1("hold_b", 4'h5, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 4'd3, TX_HOLD);
        check1("hold_c", 4'h5, 1'b0, 1'b1, 1'b0);
        tick(1'b1, TX_LOAD, TX_HOLD);
        check1("after_hold", 4'hB, 1'b1, 1'b0, 1'b1);

        // CLEAR discards the round.
        tick(1'b1, TX_LOAD, TX_HOLD);
        check1("pre_clear", 4'h5, 1'b1, 1'b1, 1'b0);
        tick(1'b1, TX_CLEAR, TX_HOLD);
        check1("clear", 4'h0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, TX_LOAD, TX_HOLD);
        check1("post_clear", 4'h5, 1'b1, 1'b1, 1'b0);

        // Reset mid-round with LOAD asserted, then restart at channel 0.
        tick(1'b0, TX_LOAD, TX_HOLD);
        check1("mid_reset", 4'h0, 1'b0, 1'b0, 1'b0);
        check("mid_reset.state1", 32'(state1), 32'd0);
        tick(1'b1, TX_LOAD, TX_HOLD);
        check1("post_reset", 4'h5, 1'b1, 1'b1, 1'b0);

        // Four-channel, 8-bit instance.
        tick(1'b1, TX_HOLD, TX_LOAD);
        check("w8.ch0", 32'(entrada2), 32'h0FF);
        check("w8.cnt0", 32'(contador2), 32'd1);
        tick(1'b1, TX_HOLD, TX_LOAD);
        check("w8.ch1", 32'(entrada2), 32'h030);
        tick(1'b1, TX_HOLD, TX_LOAD);
        check("w8.ch2", 32'(entrada2), 32'h007);
        check("w8.valid2", 32'(valid2), 32'd1);
        check("w8.cnt2", 32'(contador2), 32'd3);
`ifdef OPERAND_SEQ_PARITY_EN
        check("w8.parity2", 32'(parity2), 32'd1);
`endif
        tick(1'b1, TX_HOLD, 4'd7);
        check("w8.hold7", 32'(entrada2), 32'h007);
        check("w8.hold7_valid", 32'(valid2), 32'd0);
        check("w8.hold7_cnt", 32'(contador2), 32'd3);
        tick(1'b1, TX_HOLD, TX_LOAD);
        check("w8.ch3", 32'(entrada2), 32'h081);
        check("w8.done", 32'(done2), 32'd1);
        check("w8.cnt_wrap", 32'(contador2), 32'd0);
`ifdef OPERAND_SEQ_PARITY_EN
        check("w8.parity3", 32'(parity2), 32'd0);
`endif
        tick(1'b1, TX_HOLD, TX_CLEAR);
        check("w8.clear", 32'(entrada2), 32'd0);
        check("w8.clear_done", 32'(done2), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
